// File: rtl/matrix_load_unit_pkg.sv
// Shared matrix definitions: load FSM states and the geometry helpers
// used by the register file and the load/store units.
package matrix_load_unit_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN,
    DONE
  } load_state_e;

  // A matrix register always holds RLEN/32 rows, independent of the bus width.
  function automatic int calc_n_rows(input int rlen);
    return rlen / 32;
  endfunction

  function automatic int calc_wpr(input int rlen, input int bus_width);
    return rlen / bus_width;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matrix_load_unit_row_packer.sv
// Collects bus words into a row buffer and issues one registered
// register-file write when the last word of a row lands.
module matrix_row_packer
  import matrix_load_unit_pkg::*;
#(
  parameter int RLEN      = 128,
  parameter int BUS_WIDTH = 32,
  parameter int REG_W     = 3,
  parameter int ROW_W     = 2
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic                                    clear,
  input  logic                                    rsp_valid,
  input  logic [idx_width(RLEN/BUS_WIDTH)-1:0]    rsp_lane,
  input  logic [ROW_W-1:0]                        rsp_row,
  input  logic [REG_W-1:0]                        dest_reg,
  input  logic [BUS_WIDTH-1:0]                    rsp_data,
  output logic [REG_W-1:0]                        waddr_o,
  output logic [ROW_W-1:0]                        wrowaddr_o,
  output logic [RLEN-1:0]                         wdata_o,
  output logic                                    we_o
);

  localparam int WPR    = calc_wpr(RLEN, BUS_WIDTH);
  localparam int LANE_W = idx_width(WPR);

  logic [RLEN-1:0] row_buf_q;
  logic [RLEN-1:0] row_next;
  logic            row_last;

  // Little-endian lane placement: word w occupies bits [w*BUS_WIDTH +: BUS_WIDTH].
  always_comb begin
    row_next = row_buf_q;
    row_next[rsp_lane*BUS_WIDTH +: BUS_WIDTH] = rsp_data;
  end

  assign row_last = (rsp_lane == LANE_W'(WPR - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_buf_q  <= '0;
      waddr_o    <= '0;
      wrowaddr_o <= '0;
      wdata_o    <= '0;
      we_o       <= 1'b0;
    end else begin
      we_o <= 1'b0;
      if (clear) begin
        row_buf_q <= '0;
      end else if (rsp_valid) begin
        row_buf_q <= row_next;
        if (row_last) begin
          we_o       <= 1'b1;
          waddr_o    <= dest_reg;
          wrowaddr_o <= rsp_row;
          wdata_o    <= row_next;
        end
      end
    end
  end

endmodule

// File: rtl/matrix_load_unit.sv
// Loads one whole matrix register from memory over a 32-bit OBI-style port,
// one command at a time, and writes it row by row into the register file.
module matrix_load_unit
  import matrix_load_unit_pkg::*;
#(
  parameter int N_REGS    = 8,
  parameter int RLEN      = 128,
  parameter int BUS_WIDTH = 32
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic                                      cmd_valid_i,
  output logic                                      cmd_ready_o,
  input  logic [idx_width(N_REGS)-1:0]              cmd_reg_i,
  input  logic [31:0]                               cmd_addr_i,
  input  logic [31:0]                               cmd_stride_i,
  output logic                                      busy_o,
  output logic                                      done_o,
  output logic                                      mem_req_o,
  output logic [31:0]                               mem_addr_o,
  input  logic                                      mem_gnt_i,
  input  logic                                      mem_rvalid_i,
  input  logic [BUS_WIDTH-1:0]                      mem_rdata_i,
  output logic [idx_width(N_REGS)-1:0]              waddr_o,
  output logic [idx_width(calc_n_rows(RLEN))-1:0]   wrowaddr_o,
  output logic [RLEN-1:0]                           wdata_o,
  output logic                                      we_o
);

  localparam int N_ROWS = calc_n_rows(RLEN);
  localparam int WPR    = calc_wpr(RLEN, BUS_WIDTH);
  localparam int TOTAL  = N_ROWS * WPR;
  localparam int REG_W  = idx_width(N_REGS);
  localparam int ROW_W  = idx_width(N_ROWS);
  localparam int WPR_W  = idx_width(WPR);
  localparam int CNT_W  = $clog2(TOTAL) + 1;
  localparam logic [31:0] WORD_BYTES = 32'(BUS_WIDTH / 8);

  load_state_e      state_q;
  logic [REG_W-1:0] reg_q;
  logic [31:0]      stride_q;
  logic [31:0]      row_base_q;
  logic [WPR_W-1:0] req_word_q;
  logic [CNT_W-1:0] gnt_cnt_q;
  logic [CNT_W-1:0] rsp_cnt_q;
  logic [WPR_W-1:0] rsp_word_q;
  logic [ROW_W-1:0] rsp_row_q;
  logic             cmd_fire;
  logic             gnt_fire;
  logic             rsp_fire;

  assign cmd_fire = cmd_valid_i && cmd_ready_o;
  assign gnt_fire = mem_req_o && mem_gnt_i;
  // A response only counts while a granted request is still unanswered.
  assign rsp_fire = mem_rvalid_i && (state_q != IDLE) && (gnt_cnt_q != rsp_cnt_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cmd_ready_o <= 1'b1;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_addr_o  <= '0;
      reg_q       <= '0;
      stride_q    <= '0;
      row_base_q  <= '0;
      req_word_q  <= '0;
      gnt_cnt_q   <= '0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            state_q     <= REQ;
            cmd_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            mem_req_o   <= 1'b1;
            mem_addr_o  <= cmd_addr_i;
            row_base_q  <= cmd_addr_i;
            stride_q    <= cmd_stride_i;
            reg_q       <= cmd_reg_i;
            req_word_q  <= '0;
            gnt_cnt_q   <= '0;
          end
        end
        REQ: begin
          // The address only moves on a grant, so it holds through stalls.
          if (gnt_fire) begin
            gnt_cnt_q <= gnt_cnt_q + 1'b1;
            if (req_word_q == WPR_W'(WPR - 1)) begin
              req_word_q <= '0;
              row_base_q <= row_base_q + stride_q;
              mem_addr_o <= row_base_q + stride_q;
            end else begin
              req_word_q <= req_word_q + 1'b1;
              mem_addr_o <= mem_addr_o + WORD_BYTES;
            end
            if (gnt_cnt_q == CNT_W'(TOTAL - 1)) begin
              mem_req_o <= 1'b0;
              state_q   <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (we_o && (wrowaddr_o == ROW_W'(N_ROWS - 1))) begin
            state_q <= DONE;
            done_o  <= 1'b1;
          end
        end
        DONE: begin
          state_q     <= IDLE;
          cmd_ready_o <= 1'b1;
          busy_o      <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_cnt_q  <= '0;
      rsp_word_q <= '0;
      rsp_row_q  <= '0;
    end else if (cmd_fire) begin
      rsp_cnt_q  <= '0;
      rsp_word_q <= '0;
      rsp_row_q  <= '0;
    end else if (rsp_fire) begin
      rsp_cnt_q <= rsp_cnt_q + 1'b1;
      if (rsp_word_q == WPR_W'(WPR - 1)) begin
        rsp_word_q <= '0;
        rsp_row_q  <= rsp_row_q + 1'b1;
      end else begin
        rsp_word_q <= rsp_word_q + 1'b1;
      end
    end
  end

  matrix_row_packer #(
    .RLEN      (RLEN),
    .BUS_WIDTH (BUS_WIDTH),
    .REG_W     (REG_W),
    .ROW_W     (ROW_W)
  ) u_row_packer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear      (cmd_fire),
    .rsp_valid  (rsp_fire),
    .rsp_lane   (rsp_word_q),
    .rsp_row    (rsp_row_q),
    .dest_reg   (reg_q),
    .rsp_data   (mem_rdata_i),
    .waddr_o    (waddr_o),
    .wrowaddr_o (wrowaddr_o),
    .wdata_o    (wdata_o),
    .we_o       (we_o)
  );

  // An unsolicited response during a load is dropped; flag it in simulation.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(mem_rvalid_i && (state_q != IDLE) && (gnt_cnt_q == rsp_cnt_q)));

endmodule

// File: tb/tb_matrix_load_unit.sv
// Directed-plus-random bench for matrix_load_unit with a memory responder
// and a row-level reference model of the expected register writes.
module tb_matrix_load_unit;

  localparam int N_REGS    = 8;
  localparam int RLEN      = 128;
  localparam int BUS_WIDTH = 32;
  localparam int N_ROWS    = RLEN / 32;
  localparam int WPR       = RLEN / BUS_WIDTH;
  localparam int TOTAL     = N_ROWS * WPR;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         cmd_valid_i = 1'b0;
  logic         cmd_ready_o;
  logic [2:0]   cmd_reg_i = '0;
  logic [31:0]  cmd_addr_i = '0;
  logic [31:0]  cmd_stride_i = '0;
  logic         busy_o;
  logic         done_o;
  logic         mem_req_o;
  logic [31:0]  mem_addr_o;
  logic         mem_gnt_i = 1'b0;
  logic         mem_rvalid_i = 1'b0;
  logic [31:0]  mem_rdata_i = '0;
  logic [2:0]   waddr_o;
  logic [1:0]   wrowaddr_o;
  logic [127:0] wdata_o;
  logic         we_o;

  matrix_load_unit #(
    .N_REGS    (N_REGS),
    .RLEN      (RLEN),
    .BUS_WIDTH (BUS_WIDTH)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_reg_i    (cmd_reg_i),
    .cmd_addr_i   (cmd_addr_i),
    .cmd_stride_i (cmd_stride_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .waddr_o      (waddr_o),
    .wrowaddr_o   (wrowaddr_o),
    .wdata_o      (wdata_o),
    .we_o         (we_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  int          gnt_mode = 0;
  int          dmin = 1;
  int          dmax = 1;
  logic [31:0] mem_seed = '0;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] gnt_addr_log[$];
  int          gnt_cyc_log[$];
  logic [127:0] wr_data_log[$];
  int          wr_row_log[$];
  int          wr_reg_log[$];
  int          wr_cyc_log[$];
  int          acc_cnt = 0;
  int          acc_cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          stall_err = 0;
  int          ready_busy_err = 0;
  logic        prev_req = 1'b0;
  logic        prev_gnt = 1'b0;
  logic [31:0] prev_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ mem_seed;
  endfunction

  function automatic logic [127:0] model_row(input logic [31:0] base, input logic [31:0] stride,
                                             input int r);
    logic [127:0] v;
    logic [31:0]  a;
    v = '0;
    for (int w = 0; w < WPR; w++) begin
      a = base + 32'(r) * stride + 32'(w * (BUS_WIDTH / 8));
      v[w*BUS_WIDTH +: BUS_WIDTH] = mem_word(a);
    end
    return v;
  endfunction

  // Monitor and memory responder share one negedge process so their ordering is fixed.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      pend_addr.delete();
      pend_due.delete();
      prev_req = 1'b0;
    end else begin
      if (we_o) begin
        wr_data_log.push_back(wdata_o);
        wr_row_log.push_back(int'(wrowaddr_o));
        wr_reg_log.push_back(int'(waddr_o));
        wr_cyc_log.push_back(cyc);
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (cmd_valid_i && cmd_ready_o) begin
        acc_cnt++;
        acc_cyc = cyc;
      end
      if (busy_o && cmd_ready_o) ready_busy_err++;
      if (prev_req && !prev_gnt && mem_req_o && (mem_addr_o !== prev_addr)) stall_err++;

      mem_rvalid_i = 1'b0;
      mem_rdata_i  = $urandom;
      if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = mem_word(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      mem_gnt_i = (gnt_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (mem_req_o && mem_gnt_i) begin
        pend_addr.push_back(mem_addr_o);
        pend_due.push_back(cyc + int'($urandom_range(dmin, dmax)));
        gnt_addr_log.push_back(mem_addr_o);
        gnt_cyc_log.push_back(cyc);
      end
      prev_req  = mem_req_o;
      prev_gnt  = mem_gnt_i;
      prev_addr = mem_addr_o;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clearLogs();
    gnt_addr_log.delete();
    gnt_cyc_log.delete();
    wr_data_log.delete();
    wr_row_log.delete();
    wr_reg_log.delete();
    wr_cyc_log.delete();
  endtask

  task automatic applyStimulus(input logic [2:0] rg, input logic [31:0] addr,
                               input logic [31:0] stride, input bit hold);
    int start;
    int n;
    start        = acc_cnt;
    cmd_valid_i  = 1'b1;
    cmd_reg_i    = rg;
    cmd_addr_i   = addr;
    cmd_stride_i = stride;
    n = 0;
    while (acc_cnt == start && n < 50) begin
      tick();
      n++;
    end
    check("cmd_accept", 128'(acc_cnt - start), 128'd1);
    if (!hold) cmd_valid_i = 1'b0;
  endtask

  task automatic waitDone();
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < 2000) begin
      tick();
      n++;
    end
    check("done_seen", (done_cnt != start) ? 128'd1 : 128'd0, 128'd1);
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_cmd_ready"}, 128'(cmd_ready_o), 128'd1);
    check({tag, "_busy"},      128'(busy_o),      128'd0);
    check({tag, "_done"},      128'(done_o),      128'd0);
    check({tag, "_mem_req"},   128'(mem_req_o),   128'd0);
    check({tag, "_mem_addr"},  128'(mem_addr_o),  128'd0);
    check({tag, "_we"},        128'(we_o),        128'd0);
    check({tag, "_waddr"},     128'(waddr_o),     128'd0);
    check({tag, "_wrowaddr"},  128'(wrowaddr_o),  128'd0);
    check({tag, "_wdata"},     wdata_o,           128'd0);
  endtask

  task automatic checkOutput(input string tag, input logic [2:0] rg, input logic [31:0] base,
                             input logic [31:0] stride);
    logic [31:0] exp_addr;
    check({tag, "_wr_count"}, 128'(wr_row_log.size()), 128'(N_ROWS));
    for (int r = 0; r < wr_row_log.size(); r++) begin
      check($sformatf("%s_wr_row%0d", tag, r),  128'(wr_row_log[r]), 128'(r));
      check($sformatf("%s_wr_reg%0d", tag, r),  128'(wr_reg_log[r]), 128'(rg));
      check($sformatf("%s_wr_data%0d", tag, r), wr_data_log[r], model_row(base, stride, r));
    end
    check({tag, "_req_count"}, 128'(gnt_addr_log.size()), 128'(TOTAL));
    for (int k = 0; k < gnt_addr_log.size(); k++) begin
      exp_addr = base + 32'(k / WPR) * stride + 32'((k % WPR) * (BUS_WIDTH / 8));
      check($sformatf("%s_req_addr%0d", tag, k), 128'(gnt_addr_log[k]), 128'(exp_addr));
    end
  endtask

  initial begin
    logic [2:0]  rg;
    logic [31:0] a;
    logic [31:0] s;
    int          n;
    int          start_acc;
    int          first_done;

    repeat (3) tick();
    checkResetOutputs("reset");
    rst_ni = 1'b1;
    tick();

    // Zero-wait load with cycle-exact timing.
    clearLogs();
    gnt_mode = 0; dmin = 1; dmax = 1; mem_seed = $urandom;
    applyStimulus(3'd3, 32'h0000_1000, 32'h0000_0040, 1'b0);
    waitDone();
    checkOutput("zw", 3'd3, 32'h0000_1000, 32'h0000_0040);
    for (int r = 0; r < wr_cyc_log.size(); r++)
      check($sformatf("zw_we_cycle%0d", r), 128'(wr_cyc_log[r] - acc_cyc), 128'(6 + 4 * r));
    check("zw_done_cycle", 128'(done_cyc - acc_cyc), 128'd19);
    if (gnt_cyc_log.size() == TOTAL) begin
      check("zw_first_req_cycle", 128'(gnt_cyc_log[0] - acc_cyc), 128'd1);
      check("zw_last_req_cycle", 128'(gnt_cyc_log[TOTAL-1] - acc_cyc), 128'd16);
    end
    check("zw_ready_after_done", 128'(cmd_ready_o), 128'd1);

    // Random grant stalls.
    for (int i = 0; i < 2; i++) begin
      clearLogs();
      gnt_mode = 1; dmin = 1; dmax = 2; mem_seed = $urandom;
      rg = 3'($urandom); a = $urandom; s = $urandom;
      applyStimulus(rg, a, s, 1'b0);
      waitDone();
      checkOutput("stall", rg, a, s);
    end
    check("stall_addr_stable", 128'(stall_err), 128'd0);

    // Responses three cycles late, colliding with grants.
    clearLogs();
    gnt_mode = 0; dmin = 3; dmax = 3; mem_seed = $urandom;
    rg = 3'($urandom); a = $urandom & 32'hFFFF_FFFC; s = 32'h0000_0200;
    applyStimulus(rg, a, s, 1'b0);
    waitDone();
    checkOutput("late", rg, a, s);

    // Address wrap-around.
    clearLogs();
    gnt_mode = 1; dmin = 1; dmax = 3; mem_seed = $urandom;
    applyStimulus(3'd6, 32'hFFFF_FFF8, 32'h0000_0010, 1'b0);
    waitDone();
    checkOutput("wrap", 3'd6, 32'hFFFF_FFF8, 32'h0000_0010);
    if (gnt_addr_log.size() == TOTAL) begin
      check("wrap_req2", 128'(gnt_addr_log[2]), 128'h0000_0000);
      check("wrap_row1", 128'(gnt_addr_log[WPR]), 128'h0000_0008);
    end

    // Reset in the middle of a load, then a clean load.
    clearLogs();
    gnt_mode = 0; dmin = 1; dmax = 1; mem_seed = $urandom;
    applyStimulus(3'd5, 32'h2000_0000, 32'h0000_0100, 1'b0);
    n = 0;
    while (wr_row_log.size() < 2 && n < 100) begin
      tick();
      n++;
    end
    check("rst_rows_before", 128'(wr_row_log.size()), 128'd2);
    rst_ni = 1'b0;
    #1;
    checkResetOutputs("rst_mid");
    repeat (2) tick();
    rst_ni = 1'b1;
    repeat (8) tick();
    check("rst_no_more_we", 128'(wr_row_log.size()), 128'd2);
    check("rst_idle_ready", 128'(cmd_ready_o), 128'd1);
    clearLogs();
    mem_seed = $urandom;
    applyStimulus(3'd2, 32'h0000_8000, 32'h0000_0020, 1'b0);
    waitDone();
    checkOutput("post_rst", 3'd2, 32'h0000_8000, 32'h0000_0020);

    // Command held valid across a load: second command accepted once, right after done.
    clearLogs();
    gnt_mode = 1; dmin = 1; dmax = 2; mem_seed = $urandom;
    start_acc = acc_cnt;
    applyStimulus(3'd1, 32'h0000_4000, 32'h0000_0080, 1'b1);
    cmd_reg_i    = 3'd7;
    cmd_addr_i   = 32'h0000_6000;
    cmd_stride_i = 32'h0000_0010;
    waitDone();
    first_done = done_cyc;
    checkOutput("busy_a", 3'd1, 32'h0000_4000, 32'h0000_0080);
    clearLogs();
    n = 0;
    while (acc_cnt == start_acc + 1 && n < 50) begin
      tick();
      n++;
    end
    cmd_valid_i = 1'b0;
    check("busy_second_accept_cycle", 128'(acc_cyc - first_done), 128'd1);
    waitDone();
    checkOutput("busy_b", 3'd7, 32'h0000_6000, 32'h0000_0010);
    repeat (5) tick();
    check("busy_accept_count", 128'(acc_cnt - start_acc), 128'd2);

    // Fully random loads.
    for (int i = 0; i < 3; i++) begin
      clearLogs();
      gnt_mode = 1; dmin = 1; dmax = 4; mem_seed = $urandom;
      rg = 3'($urandom); a = $urandom; s = $urandom;
      applyStimulus(rg, a, s, 1'b0);
      waitDone();
      checkOutput("rand", rg, a, s);
    end

    check("ready_while_busy", 128'(ready_busy_err), 128'd0);
    check("addr_stable_total", 128'(stall_err), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/matrix_load_unit.md
# matrix_load_unit

Fetches one full matrix register (N_ROWS rows of RLEN bits) from memory over a 32-bit OBI-style data port. Packs the response words into rows and writes each completed row into one write port of the matrix register file. It sits directly upstream of the register file and is driven by the dispatch stage through a single-command valid/ready handshake. One load is in flight at a time.

## Interface
Parameters:
- N_REGS, 8, number of matrix registers.
- RLEN, 128, row width in bits; power of two, multiple of BUS_WIDTH.
- BUS_WIDTH, 32, memory data width in bits.
- N_ROWS (localparam), RLEN/32, rows per register.
- WPR (localparam), RLEN/BUS_WIDTH, bus words per row.

Ports:
- Clock and reset: clk_i and rst_ni. Reset is asynchronous, active-low, on rst_ni; clock is clk_i.
- clk_i  in  1  clock.
- rst_ni  in  1  async active-low reset.
- cmd_valid_i  in  1  load command valid.
- cmd_ready_o  out  1  unit idle, command accepted on valid&&ready.
- cmd_reg_i  in  $clog2(N_REGS)  destination register.
- cmd_addr_i  in  32  byte address of row 0.
- cmd_stride_i  in  32  byte distance between row starts.
- busy_o  out  1  load in progress.
- done_o  out  1  one-cycle pulse, load complete.
- mem_req_o  out  1  memory request.
- mem_addr_o  out  32  request byte address.
- mem_gnt_i  in  1  request granted.
- mem_rvalid_i  in  1  response valid.
- mem_rdata_i  in  BUS_WIDTH  response data.
- waddr_o  out  $clog2(N_REGS)  regfile write register.
- wrowaddr_o  out  $clog2(N_ROWS)  regfile write row.
- wdata_o  out  RLEN  regfile write data.
- we_o  out  1  regfile write enable.

## Operation
- FSM states: IDLE, REQ, DRAIN, DONE.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i, latch reg, base and stride; clear counters; go to REQ.
- REQ:
  - mem_req_o=1 with mem_addr_o = base + r*stride + w*(BUS_WIDTH/8), where request index k has r=k/WPR and w=k%WPR.
  - Arithmetic is modulo 2^32; wrap-around is silent.
  - mem_addr_o must stay stable while mem_req_o && !mem_gnt_i.
  - The request counter advances on each grant.
  - After grant of request N_ROWS*WPR-1, go to DRAIN.
- Responses:
  - Responses return in order, at the earliest one cycle after their grant, and may arrive in REQ or DRAIN.
  - The response counter selects the lane: word w goes to row buffer bits [w*BUS_WIDTH +: BUS_WIDTH] (little-endian).
- Row writeback:
  - When word WPR-1 of row r arrives, the next cycle drives we_o=1, waddr_o=latched reg, wrowaddr_o=r, wdata_o=assembled row.
  - The write port is registered, so one row write happens per row.
- DRAIN:
  - When the final row write issues, go to DONE.
- DONE:
  - done_o=1 for one cycle, then go to IDLE.
- busy_o = state != IDLE.
- Error handling:
  - mem_rvalid_i with no outstanding request is ignored and flagged by a simulation assertion.
  - Responses in IDLE are ignored.
- Reset, including mid-load:
  - State goes to IDLE; all counters and the row buffer clear.
  - All outputs are 0 except cmd_ready_o=1.
  - No partial row write is issued.

## Timing
- Command accept to first mem_req_o: 1 cycle (REQ entered the cycle after the handshake).
- Last response word of a row to we_o: 1 cycle.
- Final we_o to done_o: 1 cycle; cmd_ready_o returns the cycle after done_o.
- Back-to-back commands: minimum spacing is the full load plus 2 cycles; no overlap.
- Simultaneous grant and response in the same cycle: both counters advance independently.
- Stalls:
  - mem_gnt_i low holds the request.
  - Response gaps delay only the row writes.

## Structure
- Shared matrix package: load FSM state enum, and the N_ROWS/WPR derivation functions reused by the register file and the other load/store units.
- Sub-module matrix_row_packer: lane-select, accumulate, and registered write of one row.
- The top-level module holds the FSM, address generator and request/response counters.

## Test plan
All scenarios use RLEN=128, BUS_WIDTH=32 (16 words).
- Zero-wait load:
  - Stimulus: gnt=1 always, rvalid one cycle after gnt; cmd reg=3, addr=0x1000, stride=0x40, accepted at cycle 0.
  - Response: requests on cycles 1-16 to 0x1000..0x100C, 0x1040.., ..0x10CC; we_o at cycles 6/10/14/18 for rows 0-3; done_o at 19.
- Random grant stalls:
  - Stimulus: gnt low 50%.
  - Response: mem_addr_o stable during stall; final regfile contents equal memory model words packed little-endian.
- Delayed responses:
  - Stimulus: rvalid 3 cycles late, with grants and responses colliding in the same cycle.
  - Response: no lost or reordered words; exactly 4 writes.
- Address wrap:
  - Stimulus: addr=0xFFFFFFF8, stride=0x10.
  - Response: request 2 address is 0x00000000; row 1 starts at 0x00000008.
- Reset mid-load:
  - Stimulus: assert rst_ni low after row 1 is written.
  - Response: all outputs reset immediately; no further we_o; a new command completes normally.
- Busy handshake:
  - Stimulus: cmd_valid_i held high during a load.
  - Response: cmd_ready_o=0 until the cycle after done_o; the second command is accepted exactly once.
